// File: rtl/shared_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// shared_mem_arbiter_if : core-side request bus and shared-memory port bundle
// Revision: 1.0
// ============================================================================
interface shared_mem_arbiter_if #(
  parameter int NCORES = 4,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [NCORES-1:0]    core_shared;
  logic [NCORES-1:0]    core_rd;
  logic [NCORES-1:0]    core_wr;
  logic [NCORES*AW-1:0] core_addr;
  logic [NCORES*DW-1:0] core_wdata;
  logic [NCORES-1:0]    core_stall;
  logic [NCORES-1:0]    core_ack;
  logic [DW-1:0]        core_rdata;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_rd;
  logic                 mem_wr;
  logic [DW-1:0]        mem_rdata;
  logic [GW-1:0]        grant_id;

  modport slave (
    input  core_shared, core_rd, core_wr, core_addr, core_wdata, mem_rdata,
    output core_stall, core_ack, core_rdata, mem_addr, mem_wdata, mem_rd, mem_wr, grant_id
  );

  modport master (
    output core_shared, core_rd, core_wr, core_addr, core_wdata, mem_rdata,
    input  core_stall, core_ack, core_rdata, mem_addr, mem_wdata, mem_rd, mem_wr, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// shared_mem_arbiter : round-robin sequencer sharing one sync-read memory port
// Revision: 1.0
// ============================================================================
module shared_mem_arbiter #(
  parameter int NCORES = 4,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  shared_mem_arbiter_if.slave   bus
);
  localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [GW-1:0]     r_grant_id;
  logic [GW-1:0]     r_last_grant;
  logic [GW-1:0]     w_winner;
  logic [NCORES-1:0] w_req;
  logic [NCORES-1:0] w_above;
  logic [NCORES-1:0] w_masked;
  logic [NCORES-1:0] w_pick;
  logic [NCORES-1:0] w_ack;
  logic [DW-1:0]     w_rdata;
  logic              w_any_req;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_wdata;
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;
  logic              r_mem_rd;
  logic              r_mem_wr;

  assign w_req     = bus.core_shared & (bus.core_rd | bus.core_wr);
  assign w_any_req = |w_req;

  // Cores strictly above the last grant; empty when the last grant was the top core.
  assign w_above  = ~(((NCORES'(1) << r_last_grant) << 1) - NCORES'(1));
  assign w_masked = w_req & w_above;
  assign w_pick   = (|w_masked) ? w_masked : w_req;

  always_comb begin
    w_winner = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        w_winner = GW'(i);
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_rd    = 1'b0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (GW'(i) == w_winner) begin
        w_sel_addr  = bus.core_addr[i*AW +: AW];
        w_sel_wdata = bus.core_wdata[i*DW +: DW];
        w_sel_rd    = bus.core_rd[i];
        w_sel_wr    = bus.core_wr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_any_req ? S_ACCESS : S_IDLE;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack   = '0;
    w_rdata = '0;
    if (r_state == S_RESP) begin
      w_ack   = NCORES'(1) << r_grant_id;
      w_rdata = bus.mem_rdata;
    end
  end

  // Operands are captured once at grant; the memory port is driven only from these registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_id   <= '0;
      r_last_grant <= GW'(NCORES - 1);
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_id  <= w_winner;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_rd    <= w_sel_rd & ~w_sel_wr;
            r_mem_wr    <= w_sel_wr;
          end else begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
          end
        end
        S_ACCESS: begin
          r_last_grant <= r_grant_id;
          r_mem_rd     <= 1'b0;
          r_mem_wr     <= 1'b0;
        end
        default: begin
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_stall = w_req & ~w_ack;
  assign bus.core_ack   = w_ack;
  assign bus.core_rdata = w_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.grant_id   = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_shared_mem_arbiter : vector table, corner sequences and random vs model
// Revision: 1.0
// ============================================================================
module tb_shared_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic tb_clear;
  always #5 clk = ~clk;

  shared_mem_arbiter_if #(.NCORES(N), .AW(AW), .DW(DW)) bus ();

  shared_mem_arbiter #(.NCORES(N), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory content for never-written words; word 32 (byte 0x80) holds 0xDEADBEEF.
  function automatic logic [31:0] dflt(input logic [5:0] idx);
    return 32'hDEADBEEF + ({26'd0, idx ^ 6'd32} * 32'h0001_0001);
  endfunction

  logic [31:0] env_mem [64];
  logic [63:0] env_vld;
  always @(posedge clk) begin
    if (tb_clear) begin
      env_vld <= '0;
    end else if (bus.mem_wr) begin
      env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      env_vld[bus.mem_addr[7:2]] <= 1'b1;
    end
    if (bus.mem_rd) begin
      bus.mem_rdata <= env_vld[bus.mem_addr[7:2]] ? env_mem[bus.mem_addr[7:2]] : dflt(bus.mem_addr[7:2]);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.core_shared = '0;
    bus.core_rd     = '0;
    bus.core_wr     = '0;
    bus.core_addr   = '0;
    bus.core_wdata  = '0;
  endtask

  task automatic drive_core(input int c, input logic sh, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd);
    bus.core_shared[c]        = sh;
    bus.core_rd[c]            = rd;
    bus.core_wr[c]            = wr;
    bus.core_addr[c*AW +: AW] = addr;
    bus.core_wdata[c*DW +: DW] = wd;
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    reset    = 1'b1;
    tb_clear = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    tb_clear = 1'b0;
  endtask

  typedef struct {
    int          core;
    logic        sh, rd, wr;
    logic [31:0] addr, wdata;
    logic        granted, exp_rd, exp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input vec_t v);
    logic [N-1:0] oh;
    oh = v.granted ? (N'(1) << v.core) : '0;
    tick();
    clear_inputs();
    drive_core(v.core, v.sh, v.rd, v.wr, v.addr, v.wdata);
    #1;
    chk("vec_stall_t0", bus.core_stall, oh);
    chk("vec_ack_t0", bus.core_ack, 0);
    tick();
    chk("vec_mem_rd_t1", bus.mem_rd, v.exp_rd);
    chk("vec_mem_wr_t1", bus.mem_wr, v.exp_wr);
    chk("vec_stall_t1", bus.core_stall, oh);
    chk("vec_rdata_t1", bus.core_rdata, 0);
    if (v.granted) begin
      chk("vec_mem_addr", bus.mem_addr, v.addr);
      chk("vec_grant_id", bus.grant_id, v.core);
    end
    if (v.exp_wr) chk("vec_mem_wdata", bus.mem_wdata, v.wdata);
    tick();
    chk("vec_ack_t2", bus.core_ack, oh);
    chk("vec_stall_t2", bus.core_stall, 0);
    chk("vec_strobes_t2", {bus.mem_rd, bus.mem_wr}, 0);
    if (v.exp_rd) chk("vec_rdata_t2", bus.core_rdata, v.exp_rdata);
    tick();
    clear_inputs();
  endtask

  task automatic drive_reads(input logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      drive_core(i, m[i], m[i], 1'b0, 32'h200 + 32'(i * 4), 32'h0);
  endtask

  // Cores in mask all request at t=0 and hold until acked; grant j acks at t=2+3j.
  task automatic seq_check(input logic [N-1:0] mask, input int o0, input int o1,
                           input int o2, input int o3, input int n);
    int ord [4];
    logic [N-1:0] act;
    logic [N-1:0] ea;
    ord = '{o0, o1, o2, o3};
    act = mask;
    for (int t = 0; t < 3 * n; t++) begin
      tick();
      drive_reads(act);
      #1;
      ea = '0;
      if (t >= 2 && (t - 2) % 3 == 0) ea = N'(1) << ord[(t - 2) / 3];
      chk("seq_ack", bus.core_ack, ea);
      chk("seq_stall", bus.core_stall, act & ~ea);
      if (t % 3 == 1) begin
        chk("seq_grant_id", bus.grant_id, ord[t / 3]);
        chk("seq_mem_rd", bus.mem_rd, 1);
      end
      act = act & ~ea;
    end
    tick();
    drive_reads('0);
  endtask

  // Random-phase state (stimulus and high-level reference model)
  logic [N-1:0] act;
  logic [N-1:0] a_rd, a_wr;
  logic [31:0]  a_addr [N];
  logic [31:0]  a_wd   [N];
  logic [31:0]  ref_mem [64];
  logic [63:0]  ref_vld;
  int           m_last, m_free, m_ack, m_core;
  logic         m_isrd;
  logic [31:0]  m_rdata;
  logic [N-1:0] req, exp_ack;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    tb_clear = 1'b1;
    clear_inputs();
    // core, sh, rd, wr, addr, wdata, granted, exp_rd, exp_wr, exp_rdata
    vecs[0] = '{2, 1, 1, 0, 32'h80,  32'h0,        1, 1, 0, 32'hDEADBEEF};
    vecs[1] = '{3, 1, 0, 1, 32'h100, 32'h12345678, 1, 0, 1, 32'h0};
    vecs[2] = '{0, 1, 1, 0, 32'h100, 32'h0,        1, 1, 0, 32'h12345678};
    vecs[3] = '{1, 1, 1, 1, 32'h84,  32'hCAFEF00D, 1, 0, 1, 32'h0};
    vecs[4] = '{2, 1, 1, 0, 32'h84,  32'h0,        1, 1, 0, 32'hCAFEF00D};
    vecs[5] = '{1, 0, 1, 0, 32'h40,  32'h0,        0, 0, 0, 32'h0};
    vecs[6] = '{0, 1, 0, 0, 32'h44,  32'h0,        0, 0, 0, 32'h0};
    vecs[7] = '{3, 0, 0, 1, 32'h48,  32'h5,        0, 0, 0, 32'h0};
    vecs[8] = '{1, 1, 1, 0, 32'h88,  32'h0,        1, 1, 0, 32'hDEAFBEF1};

    do_reset();
    #1;
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_ack", bus.core_ack, 0);
    chk("rst_rdata", bus.core_rdata, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // All four at once after reset, then rotation after core 1 is served
    do_reset();
    seq_check(4'b1111, 0, 1, 2, 3, 4);
    seq_check(4'b0010, 1, 0, 0, 0, 1);
    seq_check(4'b0101, 2, 0, 0, 0, 2);

    // Reset during ACCESS of a core-1 read
    do_reset();
    tick();
    drive_core(1, 1, 1, 0, 32'h40, 32'h0);
    tick();
    chk("rstmid_access_rd", bus.mem_rd, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_core(0, 1, 1, 0, 32'h44, 32'h0);
    #1;
    chk("rstmid_rd_after", bus.mem_rd, 0);
    chk("rstmid_no_ack", bus.core_ack, 0);
    tick();
    chk("rstmid_no_ack2", bus.core_ack, 0);
    chk("rstmid_c0_first", bus.grant_id, 0);
    chk("rstmid_c0_addr", bus.mem_addr, 32'h44);
    tick();
    chk("rstmid_c0_ack", bus.core_ack, 4'b0001);
    tick();
    drive_core(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("rstmid_c1_grant", bus.grant_id, 1);
    chk("rstmid_c1_addr", bus.mem_addr, 32'h40);
    tick();
    chk("rstmid_c1_ack", bus.core_ack, 4'b0010);
    tick();
    clear_inputs();

    // Random traffic against the reference model
    do_reset();
    act     = '0;
    a_rd    = '0;
    a_wr    = '0;
    ref_vld = '0;
    m_last  = N - 1;
    m_free  = 0;
    m_ack   = -10;
    m_core  = 0;
    m_isrd  = 1'b0;
    m_rdata = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0;
      a_wd[i]   = '0;
    end
    for (int c = 0; c < 800; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!act[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            logic sh, rd, wr;
            sh        = ($urandom_range(0, 3) != 0);
            rd        = 1'($urandom);
            wr        = ($urandom_range(0, 2) == 0);
            a_addr[i] = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 2);
            a_wd[i]   = $urandom;
            a_rd[i]   = rd;
            a_wr[i]   = wr;
            act[i]    = sh & (rd | wr);
            drive_core(i, sh, rd, wr, a_addr[i], a_wd[i]);
          end else begin
            drive_core(i, 0, 0, 0, 32'h0, 32'h0);
          end
        end
      end
      #1;
      req     = bus.core_shared & (bus.core_rd | bus.core_wr);
      exp_ack = (c == m_ack) ? (N'(1) << m_core) : '0;
      if (c == m_ack - 1) begin
        chk("rnd_mem_rd", bus.mem_rd, a_rd[m_core] & ~a_wr[m_core]);
        chk("rnd_mem_wr", bus.mem_wr, a_wr[m_core]);
        chk("rnd_mem_addr", bus.mem_addr, a_addr[m_core]);
        chk("rnd_grant_id", bus.grant_id, m_core);
        if (a_wr[m_core]) chk("rnd_mem_wdata", bus.mem_wdata, a_wd[m_core]);
      end else begin
        chk("rnd_strobes_idle", {bus.mem_rd, bus.mem_wr}, 0);
      end
      chk("rnd_ack", bus.core_ack, exp_ack);
      chk("rnd_stall", bus.core_stall, req & ~exp_ack);
      if (exp_ack != 0 && m_isrd) chk("rnd_rdata", bus.core_rdata, m_rdata);
      act = act & ~exp_ack;

      if (c >= m_free && req != 0) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (req[idx]) begin
            m_core = idx;
            break;
          end
        end
        m_last = m_core;
        m_ack  = c + 2;
        m_free = c + 3;
        m_isrd = !a_wr[m_core];
        if (a_wr[m_core]) begin
          ref_mem[a_addr[m_core][7:2]] = a_wd[m_core];
          ref_vld[a_addr[m_core][7:2]] = 1'b1;
        end else begin
          m_rdata = ref_vld[a_addr[m_core][7:2]] ? ref_mem[a_addr[m_core][7:2]]
                                                 : dflt(a_addr[m_core][7:2]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
